// File: rtl/mmdu_pkg.sv
// Shared types and sizing helpers for the multi-mode switching-generator data unit.
package mmdu_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    // Counter must hold the terminal value 1+K*M without wrapping.
    function automatic int cnt_width(input int m, input int k);
        return $clog2(1 + k * m + 1);
    endfunction

endpackage

// File: rtl/multi_mode_data_unit_gf2_mat_vec.sv
// Combinational M x M GF(2) matrix-vector product; row i of mat sits at mat[i*M +: M].
module gf2_mat_vec #(
    parameter int M = 8
) (
    input  logic [M*M-1:0] mat,
    input  logic [M-1:0]   vec,
    output logic [M-1:0]   prod
);

    always_comb begin
        prod = '0;
        for (int i = 0; i < M; i++) begin
            prod[i] = ^(mat[i*M +: M] & vec);
        end
    end

endmodule

// File: rtl/multi_mode_data_unit.sv
// Switching-generator data unit: state stepped by one of K GF(2) matrices chosen by ctrl.
// Handshake: a config word transfers on a rising edge where cfg_valid && cfg_ready.
module multi_mode_data_unit
    import mmdu_pkg::*;
#(
    parameter int  M     = 8,
    parameter int  K     = 4,
    localparam int SEL_W = $clog2(K)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [M-1:0]     cfg_data,
    input  logic             cfg_restart,
    input  logic             en,
    input  logic [SEL_W-1:0] ctrl,
    output logic             out,
    output logic             out_valid,
    output logic             bad_sel,
    output logic             lock_err
);

    localparam int              NWORDS = 1 + K * M;
    localparam int              CW     = cnt_width(M, K);
    localparam logic [SEL_W:0]  K_EXT  = (SEL_W + 1)'(K);

    fsm_t            fsm;
    fsm_t            fsm_next;
    logic [CW-1:0]   word_cnt;
    logic [M-1:0]    state;
    logic [M-1:0]    mat [K*M];
    logic [M*M-1:0]  sel_mat;
    logic [M-1:0]    prod;
    logic            sel_ok;
    logic            accept;
    logic            last_word;
    logic            step;

    // Compare in one extra bit so the check stays meaningful when K is a power of 2.
    always_comb begin
        sel_ok    = ({1'b0, ctrl} < K_EXT);
        accept    = cfg_valid && (fsm == LOAD) && !cfg_restart;
        last_word = (word_cnt == CW'(NWORDS - 1));
        step      = (fsm == RUN) && en && sel_ok && !cfg_restart;
    end

    // Select one matrix ahead of a single shared product unit.
    always_comb begin
        sel_mat = '0;
        for (int k = 0; k < K; k++) begin
            if (ctrl == SEL_W'(k)) begin
                for (int i = 0; i < M; i++) begin
                    sel_mat[i*M +: M] = mat[k*M + i];
                end
            end
        end
    end

    gf2_mat_vec #(.M(M)) u_mat_vec (
        .mat  (sel_mat),
        .vec  (state),
        .prod (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) fsm <= LOAD;
        else     fsm <= fsm_next;
    end

    always_comb begin
        fsm_next  = fsm;
        cfg_ready = 1'b0;
        out_valid = 1'b0;
        case (fsm)
            LOAD: begin
                cfg_ready = 1'b1;
                if (accept && last_word) fsm_next = RUN;
            end
            RUN: begin
                out_valid = 1'b1;
            end
            default: fsm_next = LOAD;
        endcase
        if (cfg_restart) fsm_next = LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
            state    <= '0;
            lock_err <= 1'b0;
            bad_sel  <= 1'b0;
            for (int r = 0; r < K * M; r++) mat[r] <= '0;
        end else begin
            bad_sel <= (fsm == RUN) && en && !sel_ok && !cfg_restart;
            if (cfg_restart) begin
                word_cnt <= '0;
                lock_err <= 1'b0;
            end else begin
                if (accept) begin
                    if (word_cnt != CW'(NWORDS)) word_cnt <= word_cnt + CW'(1);
                    if (word_cnt == '0) state <= cfg_data;
                    // Word r+1 carries flattened row r (matrix r/M, row r%M).
                    for (int r = 0; r < K * M; r++) begin
                        if (word_cnt == CW'(r + 1)) mat[r] <= cfg_data;
                    end
                end else if (step) begin
                    state <= prod;
                end
                if ((fsm == RUN) && (state == '0)) lock_err <= 1'b1;
            end
        end
    end

    assign out = state[M-1];

endmodule

// File: tb/tb_multi_mode_data_unit.sv
// Directed bench for multi_mode_data_unit: M=4,K=2 main instance plus an M=4,K=3 instance.
module tb_multi_mode_data_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cfg_valid, cfg_ready, cfg_restart, en, ctrl;
    logic [3:0] cfg_data;
    logic       out, out_valid, bad_sel, lock_err;

    logic       k3_cfg_valid, k3_cfg_ready, k3_cfg_restart, k3_en;
    logic [1:0] k3_ctrl;
    logic [3:0] k3_cfg_data;
    logic       k3_out, k3_out_valid, k3_bad_sel, k3_lock_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] words_q[$];

    multi_mode_data_unit #(.M(4), .K(2)) u_dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_restart(cfg_restart), .en(en), .ctrl(ctrl),
        .out(out), .out_valid(out_valid), .bad_sel(bad_sel), .lock_err(lock_err)
    );

    multi_mode_data_unit #(.M(4), .K(3)) u_k3 (
        .clk(clk), .rst(rst), .cfg_valid(k3_cfg_valid), .cfg_ready(k3_cfg_ready),
        .cfg_data(k3_cfg_data), .cfg_restart(k3_cfg_restart), .en(k3_en), .ctrl(k3_ctrl),
        .out(k3_out), .out_valid(k3_out_valid), .bad_sel(k3_bad_sel), .lock_err(k3_lock_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic load_main(input bit rnd);
        int   accepted;
        int   guard;
        logic hs;
        logic early_run;
        accepted  = 0;
        early_run = 1'b0;
        for (int w = 0; w < words_q.size(); w++) begin
            guard    = 0;
            cfg_data = words_q[w];
            do begin
                cfg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_valid) early_run = 1'b1;
                hs = cfg_valid && cfg_ready;
                tick();
                guard++;
            end while (!hs && guard < 40);
            if (hs) accepted++;
        end
        cfg_valid = 1'b0;
        check("load_accepted", 32'(accepted), 32'(words_q.size()));
        check("load_no_early_run", 32'(early_run), 32'd0);
        check("load_out_valid", 32'(out_valid), 32'd1);
        check("load_ready_low", 32'(cfg_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_rot[3];
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_restart = 1'b0; cfg_data = '0; en = 1'b0; ctrl = 1'b0;
        k3_cfg_valid = 1'b0; k3_cfg_restart = 1'b0; k3_cfg_data = '0; k3_en = 1'b0; k3_ctrl = '0;

        // Reset
        repeat (2) tick();
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_lock_err", 32'(lock_err), 32'd0);
        check("rst_bad_sel", 32'(bad_sel), 32'd0);
        rst = 1'b0;

        // Load seed 0001, T0 identity, T1 rotate-left
        words_q = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                    4'b1000, 4'b0001, 4'b0010, 4'b0100};
        load_main(1'b0);
        check("seed_state", 32'(u_dut.state), 32'h1);
        en = 1'b1; ctrl = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ident_out", 32'(out), 32'd0);
            check("ident_state", 32'(u_dut.state), 32'h1);
        end
        exp_rot = '{4'b0010, 4'b0100, 4'b1000};
        ctrl = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rot_state", 32'(u_dut.state), 32'(exp_rot[i]));
            check("rot_out", 32'(out), (i == 2) ? 32'd1 : 32'd0);
        end
        en = 1'b0;
        repeat (2) tick();
        check("hold_state", 32'(u_dut.state), 32'h8);
        cfg_valid = 1'b1; cfg_data = 4'b0110;
        tick();
        cfg_valid = 1'b0;
        check("run_ignores_cfg", 32'(u_dut.state), 32'h8);
        check("run_lock_err", 32'(lock_err), 32'd0);

        // Restart then back-pressured load: seed 0101, T0 identity, T1 zero
        cfg_restart = 1'b1;
        tick();
        cfg_restart = 1'b0;
        check("restart_out_valid", 32'(out_valid), 32'd0);
        check("restart_ready", 32'(cfg_ready), 32'd1);
        check("restart_cnt", 32'(u_dut.word_cnt), 32'd0);
        check("restart_keeps_state", 32'(u_dut.state), 32'h8);
        words_q = '{4'b0101, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                    4'b0000, 4'b0000, 4'b0000, 4'b0000};
        load_main(1'b1);
        check("bp_seed", 32'(u_dut.state), 32'h5);

        // Zero lock
        en = 1'b1; ctrl = 1'b0;
        tick();
        check("pre_lock_state", 32'(u_dut.state), 32'h5);
        ctrl = 1'b1;
        tick();
        en = 1'b0;
        check("lock_state_zero", 32'(u_dut.state), 32'h0);
        check("lock_not_yet", 32'(lock_err), 32'd0);
        tick();
        check("lock_set", 32'(lock_err), 32'd1);
        en = 1'b1; ctrl = 1'b0;
        repeat (3) tick();
        en = 1'b0;
        check("lock_sticky", 32'(lock_err), 32'd1);
        cfg_restart = 1'b1;
        tick();
        cfg_restart = 1'b0;
        check("lock_cleared", 32'(lock_err), 32'd0);

        // Reset mid-load discards partial config
        cfg_valid = 1'b1; cfg_data = 4'b1010;
        repeat (3) tick();
        cfg_valid = 1'b0;
        check("partial_seed", 32'(u_dut.state), 32'hA);
        check("partial_cnt", 32'(u_dut.word_cnt), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state", 32'(u_dut.state), 32'h0);
        check("midrst_cnt", 32'(u_dut.word_cnt), 32'd0);
        check("midrst_mat0", 32'(u_dut.mat[0]), 32'h0);
        check("midrst_ready", 32'(cfg_ready), 32'd1);

        // Restart collisions
        words_q = '{4'b0011, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                    4'b1000, 4'b0001, 4'b0010, 4'b0100};
        load_main(1'b0);
        en = 1'b1; ctrl = 1'b1;
        tick();
        check("pre_coll_state", 32'(u_dut.state), 32'h6);
        cfg_restart = 1'b1;
        tick();
        cfg_restart = 1'b0; en = 1'b0;
        check("coll_state", 32'(u_dut.state), 32'h6);
        check("coll_out_valid", 32'(out_valid), 32'd0);
        check("coll_lock_err", 32'(lock_err), 32'd0);
        check("coll_cnt", 32'(u_dut.word_cnt), 32'd0);
        check("coll_bad_sel", 32'(bad_sel), 32'd0);
        cfg_valid = 1'b1; cfg_data = 4'b1111; cfg_restart = 1'b1;
        tick();
        cfg_restart = 1'b0;
        check("coll_cfg_state", 32'(u_dut.state), 32'h6);
        check("coll_cfg_cnt", 32'(u_dut.word_cnt), 32'd0);
        tick();
        cfg_valid = 1'b0;
        check("post_coll_seed", 32'(u_dut.state), 32'hF);
        check("post_coll_cnt", 32'(u_dut.word_cnt), 32'd1);

        // K=3: seed 0001, T0 identity, T1 and T2 rotate-left
        words_q = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                    4'b1000, 4'b0001, 4'b0010, 4'b0100,
                    4'b1000, 4'b0001, 4'b0010, 4'b0100};
        k3_cfg_valid = 1'b1;
        for (int w = 0; w < words_q.size(); w++) begin
            k3_cfg_data = words_q[w];
            tick();
        end
        k3_cfg_valid = 1'b0;
        check("k3_out_valid", 32'(k3_out_valid), 32'd1);
        check("k3_bad_sel_idle", 32'(k3_bad_sel), 32'd0);
        k3_en = 1'b1; k3_ctrl = 2'b11;
        tick();
        k3_en = 1'b0;
        check("k3_bad_state", 32'(u_k3.state), 32'h1);
        check("k3_bad_sel_hi", 32'(k3_bad_sel), 32'd1);
        tick();
        check("k3_bad_sel_lo", 32'(k3_bad_sel), 32'd0);
        check("k3_bad_state_hold", 32'(u_k3.state), 32'h1);
        k3_en = 1'b1; k3_ctrl = 2'b10;
        tick();
        k3_en = 1'b0;
        check("k3_t2_state", 32'(u_k3.state), 32'h2);
        check("k3_t2_bad_sel", 32'(k3_bad_sel), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
